// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART-driven program loader: FSM encoding,
// host command bytes and the end-of-program marker.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_LOADED,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0]  CMD_LOAD   = 8'h4C;
    localparam logic [7:0]  CMD_RUN    = 8'h52;
    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the loader and the
// MIPS program memory write port plus the CPU enable/status lines.
interface program_loader_if #(
    parameter int LEN      = 32,
    parameter int NB_PADDR = 5
);
    logic [7:0]          i_rx_data;
    logic                i_rx_valid;
    logic                o_wr_en;
    logic [NB_PADDR-1:0] o_wr_addr;
    logic [LEN-1:0]      o_wr_data;
    logic                o_cpu_en;
    logic                o_done;
    logic                o_error;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_wr_en, o_wr_addr, o_wr_data, o_cpu_en, o_done, o_error
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_wr_en, o_wr_addr, o_wr_data, o_cpu_en, o_done, o_error
    );
endinterface

// File: rtl/program_loader.sv
// Loads big-endian instruction words received over UART into program memory,
// then releases the MIPS pipeline on the run command.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int LEN               = 32,
    parameter int RAM_DEPTH_PROGRAM = 32,
    parameter int NB_PADDR          = $clog2(RAM_DEPTH_PROGRAM)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    program_loader_if.slave     bus
);

    // Address counter is one bit wider so "memory full" is representable without wrapping.
    localparam logic [NB_PADDR:0] DEPTH_LIMIT = (NB_PADDR+1)'(RAM_DEPTH_PROGRAM);

    loader_state_t     state, state_next;
    logic [1:0]        byte_cnt, byte_cnt_next;
    logic [NB_PADDR:0] word_addr, word_addr_next;
    logic [LEN-1:0]    word, word_next;
    logic [LEN-1:0]    assembled;
    logic [NB_PADDR:0] base_addr;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            byte_cnt  <= '0;
            word_addr <= '0;
            word      <= '0;
        end else begin
            byte_cnt  <= byte_cnt_next;
            word_addr <= word_addr_next;
            word      <= word_next;
        end
    end

    always_comb begin
        state_next     = state;
        byte_cnt_next  = byte_cnt;
        word_addr_next = word_addr;
        word_next      = word;
        // Shifting in at the bottom leaves the first byte of a word in the top lane.
        assembled      = {word[LEN-9:0], bus.i_rx_data};
        base_addr      = (state == ST_WRITE) ? word_addr + (NB_PADDR+1)'(1) : word_addr;

        case (state)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_LOAD) begin
                        state_next     = ST_RECV;
                        byte_cnt_next  = '0;
                        word_addr_next = '0;
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end

            // WRITE also accepts a byte so a back-to-back stream loses nothing.
            ST_RECV, ST_WRITE: begin
                word_addr_next = base_addr;
                state_next     = ST_RECV;
                if (bus.i_rx_valid) begin
                    word_next     = assembled;
                    byte_cnt_next = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (assembled == LEN'(END_MARKER)) begin
                            state_next = ST_LOADED;
                        end else if (base_addr == DEPTH_LIMIT) begin
                            state_next = ST_ERROR;
                        end else begin
                            state_next = ST_WRITE;
                        end
                    end
                end
            end

            ST_LOADED: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == CMD_RUN) begin
                        state_next = ST_RUN;
                    end else if (bus.i_rx_data == CMD_LOAD) begin
                        state_next     = ST_RECV;
                        byte_cnt_next  = '0;
                        word_addr_next = '0;
                    end
                end
            end

            default: begin
                state_next = state;
            end
        endcase
    end

    // Outputs decode the state register directly so reset clears them without waiting a clock.
    assign bus.o_wr_en   = (state == ST_WRITE);
    assign bus.o_wr_addr = word_addr[NB_PADDR-1:0];
    assign bus.o_wr_data = word;
    assign bus.o_cpu_en  = (state == ST_RUN);
    assign bus.o_done    = (state == ST_LOADED) || (state == ST_RUN);
    assign bus.o_error   = (state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed load/run/error scenarios
// plus randomized loads compared cycle by cycle against a byte-stream model.
module tb_program_loader;

    localparam int LEN      = 32;
    localparam int DEPTH    = 32;
    localparam int NB_PADDR = 5;

    localparam int M_IDLE    = 0;
    localparam int M_LOADING = 1;
    localparam int M_LOADED  = 2;
    localparam int M_RUN     = 3;
    localparam int M_ERROR   = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;

    program_loader_if #(.LEN(LEN), .NB_PADDR(NB_PADDR)) bus ();

    program_loader #(
        .LEN(LEN),
        .RAM_DEPTH_PROGRAM(DEPTH),
        .NB_PADDR(NB_PADDR)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: a mode, the bytes of the word in flight, words stored so far.
    int          m_mode = M_IDLE;
    logic [7:0]  m_buf[$];
    int          m_words = 0;
    bit          exp_wr = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_mode  = M_IDLE;
        m_buf.delete();
        m_words = 0;
        exp_wr  = 1'b0;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        logic [31:0] w;
        case (m_mode)
            M_IDLE: begin
                if (b == 8'h4C) begin
                    m_mode = M_LOADING;
                    m_buf.delete();
                    m_words = 0;
                end else begin
                    m_mode = M_ERROR;
                end
            end
            M_LOADING: begin
                m_buf.push_back(b);
                if (m_buf.size() == 4) begin
                    w = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                    m_buf.delete();
                    if (w == 32'hFFFF_FFFF) begin
                        m_mode = M_LOADED;
                    end else if (m_words == DEPTH) begin
                        m_mode = M_ERROR;
                    end else begin
                        exp_wr   = 1'b1;
                        exp_addr = 32'(m_words);
                        exp_data = w;
                        m_words++;
                    end
                end
            end
            M_LOADED: begin
                if (b == 8'h52) begin
                    m_mode = M_RUN;
                end else if (b == 8'h4C) begin
                    m_mode = M_LOADING;
                    m_buf.delete();
                    m_words = 0;
                end
            end
            default: begin
            end
        endcase
    endfunction

    // Called on a falling edge: check this cycle's outputs, then drive the next input.
    task automatic applyStimulus(input bit valid, input logic [7:0] data);
        checkOutput("wr_en", 32'(bus.o_wr_en), 32'(exp_wr));
        if (exp_wr) begin
            checkOutput("wr_addr", 32'(bus.o_wr_addr), exp_addr);
            checkOutput("wr_data", bus.o_wr_data, exp_data);
        end
        checkOutput("done",   32'(bus.o_done),   32'(m_mode == M_LOADED || m_mode == M_RUN));
        checkOutput("cpu_en", 32'(bus.o_cpu_en), 32'(m_mode == M_RUN));
        checkOutput("error",  32'(bus.o_error),  32'(m_mode == M_ERROR));
        exp_wr         = 1'b0;
        bus.i_rx_valid = valid;
        bus.i_rx_data  = valid ? data : 8'($urandom);
        if (valid) modelByte(data);
        @(negedge i_clk);
    endtask

    task automatic sendByte(input logic [7:0] data, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, data);
    endtask

    task automatic sendWord(input logic [31:0] w, input int max_gap);
        for (int k = 3; k >= 0; k--) sendByte(w[8*k +: 8], max_gap);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic applyReset();
        i_rst          = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        #1;
        checkOutput("rst_wr_en",   32'(bus.o_wr_en),   32'h0);
        checkOutput("rst_wr_addr", 32'(bus.o_wr_addr), 32'h0);
        checkOutput("rst_wr_data", bus.o_wr_data,      32'h0);
        checkOutput("rst_done",    32'(bus.o_done),    32'h0);
        checkOutput("rst_cpu_en",  32'(bus.o_cpu_en),  32'h0);
        checkOutput("rst_error",   32'(bus.o_error),   32'h0);
        modelReset();
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int nwords;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        applyReset();

        $display("[TB] basic load and run");
        sendByte(8'h4C, 0);
        sendWord(32'h0011_2233, 0);
        sendWord(32'h8C01_0004, 0);
        sendWord(32'hFFFF_FFFF, 0);
        idleCycles(2);
        sendByte(8'h52, 0);
        idleCycles(1);
        sendByte(8'h4C, 0);
        sendWord(32'h1234_5678, 0);
        idleCycles(3);

        $display("[TB] overflow");
        applyReset();
        sendByte(8'h4C, 0);
        for (int k = 0; k < DEPTH + 1; k++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            sendWord(w, 0);
        end
        idleCycles(1);
        sendByte(8'h4C, 0);
        sendWord(32'hFFFF_FFFF, 0);
        idleCycles(2);

        $display("[TB] bad command");
        applyReset();
        sendByte(8'h41, 0);
        sendByte(8'h4C, 1);
        sendWord(32'h0102_0304, 1);
        idleCycles(2);

        $display("[TB] zero-length load and reload");
        applyReset();
        sendByte(8'h4C, 0);
        sendWord(32'hFFFF_FFFF, 0);
        idleCycles(1);
        sendByte(8'h4C, 0);
        sendWord(32'hCAFE_F00D, 2);
        sendWord(32'hFFFF_FFFF, 2);
        idleCycles(2);

        $display("[TB] reset mid-word and mid-write");
        applyReset();
        sendByte(8'h4C, 0);
        sendByte(8'hAA, 0);
        sendByte(8'hBB, 0);
        applyReset();
        sendByte(8'h4C, 0);
        sendWord(32'h0102_0304, 0);
        sendWord(32'hFFFF_FFFF, 0);
        idleCycles(2);
        applyReset();
        sendByte(8'h4C, 0);
        sendWord(32'h5566_7788, 0);
        applyReset();
        idleCycles(2);

        $display("[TB] randomized loads");
        for (int r = 0; r < 8; r++) begin
            applyReset();
            sendByte(($urandom_range(9, 0) == 0) ? 8'h4C + 8'h1 : 8'h4C, 2);
            nwords = $urandom_range(DEPTH + 2, 0);
            for (int k = 0; k < nwords; k++) begin
                w = $urandom;
                if ($urandom_range(19, 0) == 0) w = 32'hFFFF_FFFF;
                sendWord(w, (r % 2 == 0) ? 0 : 2);
            end
            sendWord(32'hFFFF_FFFF, 1);
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(3, 0))
                    0: sendByte(8'h52, 1);
                    1: sendByte(8'h4C, 1);
                    default: sendByte(8'($urandom), 1);
                endcase
            end
            idleCycles(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
